// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

    // Transmitter FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_e;

    // 8N1 framing
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus UART line/status bundle for fifo_uart_tx.
interface fifo_uart_tx_if;
    import fifo_uart_tx_pkg::*;

    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_rd;
    logic                 tx;
    logic                 busy;
    logic                 tx_done;

    // Environment side: owns the FIFO, observes the line
    modport master (
        output fifo_empty, fifo_data,
        input  fifo_rd, tx, busy, tx_done
    );

    // Transmitter side
    modport slave (
        input  fifo_empty, fifo_data,
        output fifo_rd, tx, busy, tx_done
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. Shared with the future receiver.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_end
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    assign cnt     = cnt_r;
    assign bit_end = en && (cnt_r == LAST);

    // Bit-period counter with wrap at the bit boundary and synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (bit_end) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the keyboard/touch FIFO and sends them as UART 8N1,
// LSB first. All outputs are registered from next-state values so the
// line timing matches the FSM state exactly.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic          clk,
    input  logic          reset,
    fifo_uart_tx_if.slave bus
);
    // tx_done must be high during the cycle where the counter reads LAST,
    // so it is loaded one count earlier
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_e            state_r, next_state_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic [2:0]           bit_idx_r, bit_idx_next_s;
    logic [CNT_W-1:0]     cnt_s;
    logic                 bit_end_s;
    logic                 baud_en_s;
    logic                 tx_r, fifo_rd_r, busy_r, tx_done_r;
    logic                 tx_next_s, fifo_rd_next_s, busy_next_s, tx_done_next_s;

    assign baud_en_s = (state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clr     (!baud_en_s),
        .en      (baud_en_s),
        .cnt     (cnt_s),
        .bit_end (bit_end_s)
    );

    // Next-state, shift register and bit index logic
    always_comb begin
        next_state_s   = state_r;
        shift_next_s   = shift_r;
        bit_idx_next_s = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.fifo_empty) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                shift_next_s = bus.fifo_data;
                next_state_s = ST_START;
            end
            ST_START: begin
                if (bit_end_s) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_next_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (bit_idx_r == 3'(DATA_BITS - 1)) begin
                        bit_idx_next_s = 3'd0;
                        next_state_s   = ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                        next_state_s   = ST_DATA;
                    end
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (!bus.fifo_empty) begin
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_STOP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        tx_next_s = 1'b1;
        case (next_state_s)
            ST_START: tx_next_s = 1'b0;
            ST_DATA:  tx_next_s = shift_next_s[0];
            default:  tx_next_s = 1'b1;
        endcase
        fifo_rd_next_s = (next_state_s == ST_FETCH);
        busy_next_s    = (next_state_s != ST_IDLE);
        tx_done_next_s = (state_r == ST_STOP) && (cnt_s == PRE_LAST);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r   <= {DATA_BITS{1'b0}};
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
            fifo_rd_r <= 1'b0;
            busy_r    <= 1'b0;
            tx_done_r <= 1'b0;
        end else begin
            shift_r   <= shift_next_s;
            bit_idx_r <= bit_idx_next_s;
            tx_r      <= tx_next_s;
            fifo_rd_r <= fifo_rd_next_s;
            busy_r    <= busy_next_s;
            tx_done_r <= tx_done_next_s;
        end
    end

    assign bus.tx      = tx_r;
    assign bus.fifo_rd = fifo_rd_r;
    assign bus.busy    = busy_r;
    assign bus.tx_done = tx_done_r;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx at 4, 2 and 7 clocks/bit.
module tb_fifo_uart_tx;
    import fifo_uart_tx_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fifo_uart_tx_if if4 ();
    fifo_uart_tx_if if2 ();
    fifo_uart_tx_if if7 ();

    fifo_uart_tx #(.CLKS_PER_BIT(4), .CNT_W(16)) u_dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    fifo_uart_tx #(.CLKS_PER_BIT(2), .CNT_W(16)) u_dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
    fifo_uart_tx #(.CLKS_PER_BIT(7), .CNT_W(16)) u_dut7 (.clk(clk), .reset(reset), .bus(if7.slave));

    // FIFO models: one-cycle read latency, pointers written by one process each
    logic [7:0] mem4 [0:7];
    int wr4 = 0, rd4 = 0, wr2 = 0, rd2 = 0, wr7 = 0, rd7 = 0;

    assign if4.fifo_empty = (rd4 == wr4);
    assign if2.fifo_empty = (rd2 == wr2);
    assign if7.fifo_empty = (rd7 == wr7);

    // Read port of the 4 clocks/bit FIFO model
    always @(posedge clk) if (if4.fifo_rd === 1'b1) begin
        if4.fifo_data <= mem4[rd4 % 8];
        rd4 <= rd4 + 1;
    end

    // Read port of the 2 clocks/bit FIFO model
    always @(posedge clk) if (if2.fifo_rd === 1'b1) begin
        if2.fifo_data <= 8'hA5;
        rd2 <= rd2 + 1;
    end

    // Read port of the 7 clocks/bit FIFO model
    always @(posedge clk) if (if7.fifo_rd === 1'b1) begin
        if7.fifo_data <= 8'hA5;
        rd7 <= rd7 + 1;
    end

    // Captured waveforms and expected waveforms
    logic      tx_a [0:299];
    logic      rd_a [0:299];
    logic      busy_a [0:299];
    logic      done_a [0:299];
    tx_state_e st_a [0:299];
    logic      etx [0:299];
    logic      erd [0:299];
    logic      ebusy [0:299];
    logic      edone [0:299];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input int inst, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case (inst)
                0: begin
                    tx_a[k] = if4.tx; rd_a[k] = if4.fifo_rd; busy_a[k] = if4.busy;
                    done_a[k] = if4.tx_done; st_a[k] = u_dut4.state_r;
                end
                1: begin
                    tx_a[k] = if2.tx; rd_a[k] = if2.fifo_rd; busy_a[k] = if2.busy;
                    done_a[k] = if2.tx_done; st_a[k] = u_dut2.state_r;
                end
                default: begin
                    tx_a[k] = if7.tx; rd_a[k] = if7.fifo_rd; busy_a[k] = if7.busy;
                    done_a[k] = if7.tx_done; st_a[k] = u_dut7.state_r;
                end
            endcase
        end
    endtask

    task automatic exp_clear();
        for (int k = 0; k < 300; k++) begin
            etx[k] = 1'b1; erd[k] = 1'b0; ebusy[k] = 1'b0; edone[k] = 1'b0;
        end
    endtask

    // Expected frame whose FETCH cycle is index f
    task automatic exp_frame(input int f, input logic [7:0] b, input int cpb);
        logic bv;
        erd[f] = 1'b1;
        for (int k = f; k < f + 2 + 10 * cpb; k++) ebusy[k] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bv = 1'b0;
            else if (i == 9) bv = 1'b1;
            else bv = b[i-1];
            for (int j = 0; j < cpb; j++) etx[f + 2 + i * cpb + j] = bv;
        end
        edone[f + 1 + 10 * cpb] = 1'b1;
    endtask

    task automatic compare_wave(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s tx[%0d]", tag, k), 32'(tx_a[k]), 32'(etx[k]));
            chk($sformatf("%s fifo_rd[%0d]", tag, k), 32'(rd_a[k]), 32'(erd[k]));
            chk($sformatf("%s busy[%0d]", tag, k), 32'(busy_a[k]), 32'(ebusy[k]));
            chk($sformatf("%s tx_done[%0d]", tag, k), 32'(done_a[k]), 32'(edone[k]));
        end
    endtask

    function automatic int find_fall(input int from, input int n);
        for (int k = (from < 1) ? 1 : from; k < n; k++)
            if (tx_a[k-1] === 1'b1 && tx_a[k] === 1'b0) return k;
        return -1;
    endfunction

    function automatic logic [7:0] decode(input int s, input int cpb);
        logic [7:0] b;
        b = 8'h00;
        if (s < 0) return 8'h00;
        for (int i = 0; i < 8; i++) b[i] = tx_a[s + (i + 1) * cpb + cpb / 2];
        return b;
    endfunction

    function automatic int count_rd(input int n);
        int c;
        c = 0;
        for (int k = 0; k < n; k++) if (rd_a[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int find_done(input int n);
        for (int k = 0; k < n; k++) if (done_a[k] === 1'b1) return k;
        return -1;
    endfunction

    initial begin
        int s1, s2, s3, p0, c_rd, c_low, c_busy;

        // 1: reset held 3 cycles with a byte waiting
        mem4[0] = 8'hEE;
        wr4 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst tx c%0d", i), 32'(if4.tx), 32'd1);
            chk($sformatf("rst fifo_rd c%0d", i), 32'(if4.fifo_rd), 32'd0);
            chk($sformatf("rst busy c%0d", i), 32'(if4.busy), 32'd0);
            chk($sformatf("rst tx_done c%0d", i), 32'(if4.tx_done), 32'd0);
        end
        chk("rst no pop", 32'(rd4), 32'd0);
        @(posedge clk); #1;
        wr4 = rd4;
        reset = 1'b0;

        // 2: single byte 'h'
        @(posedge clk); #1;
        mem4[wr4 % 8] = 8'h68; wr4++;
        capture(0, 50);
        exp_clear();
        exp_frame(1, 8'h68, 4);
        compare_wave("single", 50);
        chk("single decode", 32'(decode(find_fall(0, 50), 4)), 32'h68);
        chk("single idle", 32'(st_a[49]), 32'(ST_IDLE));

        // 3: back-to-back "abc"
        @(posedge clk); #1;
        p0 = rd4;
        mem4[wr4 % 8] = 8'h61; wr4++;
        mem4[wr4 % 8] = 8'h62; wr4++;
        mem4[wr4 % 8] = 8'h63; wr4++;
        capture(0, 140);
        exp_clear();
        exp_frame(1, 8'h61, 4);
        exp_frame(43, 8'h62, 4);
        exp_frame(85, 8'h63, 4);
        compare_wave("b2b", 140);
        s1 = find_fall(0, 140);
        s2 = find_fall(s1 + 40, 140);
        s3 = find_fall(s2 + 40, 140);
        chk("b2b rd pulses", 32'(count_rd(140)), 32'd3);
        chk("b2b pops", 32'(rd4 - p0), 32'd3);
        chk("b2b start1", 32'(s1), 32'd3);
        chk("b2b gap12", 32'(s2 - s1), 32'd42);
        chk("b2b gap23", 32'(s3 - s2), 32'd42);
        chk("b2b byte1", 32'(decode(s1, 4)), 32'h61);
        chk("b2b byte2", 32'(decode(s2, 4)), 32'h62);
        chk("b2b byte3", 32'(decode(s3, 4)), 32'h63);
        chk("b2b idle", 32'(st_a[139]), 32'(ST_IDLE));

        // 4: empty FIFO never popped
        c_rd = 0; c_low = 0; c_busy = 0;
        p0 = rd4;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if4.fifo_rd !== 1'b0) c_rd++;
            if (if4.tx !== 1'b1) c_low++;
            if (if4.busy !== 1'b0) c_busy++;
        end
        chk("empty rd cycles", 32'(c_rd), 32'd0);
        chk("empty tx low cycles", 32'(c_low), 32'd0);
        chk("empty busy cycles", 32'(c_busy), 32'd0);
        chk("empty pops", 32'(rd4 - p0), 32'd0);

        // 5: reset during data bit 3 of 0x55, then a fresh frame of 0x3C
        @(posedge clk); #1;
        p0 = rd4;
        mem4[wr4 % 8] = 8'h55; wr4++;
        mem4[wr4 % 8] = 8'h3C; wr4++;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst bit3 on line", 32'(if4.tx), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        capture(0, 50);
        chk("midrst state", 32'(st_a[0]), 32'(ST_IDLE));
        exp_clear();
        exp_frame(1, 8'h3C, 4);
        compare_wave("midrst", 50);
        chk("midrst decode", 32'(decode(find_fall(0, 50), 4)), 32'h3C);
        chk("midrst pops", 32'(rd4 - p0), 32'd2);

        // 6: bit-period sweep, 2 and 7 clocks/bit with 0xA5
        @(posedge clk); #1;
        wr2++;
        capture(1, 30);
        exp_clear();
        exp_frame(1, 8'hA5, 2);
        compare_wave("cpb2", 30);
        s1 = find_fall(0, 30);
        chk("cpb2 decode", 32'(decode(s1, 2)), 32'hA5);
        chk("cpb2 frame len", 32'(find_done(30) - s1 + 1), 32'd20);

        @(posedge clk); #1;
        wr7++;
        capture(2, 80);
        exp_clear();
        exp_frame(1, 8'hA5, 7);
        compare_wave("cpb7", 80);
        s1 = find_fall(0, 80);
        chk("cpb7 decode", 32'(decode(s1, 7)), 32'hA5);
        chk("cpb7 frame len", 32'(find_done(80) - s1 + 1), 32'd70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
